// File: rtl/exec_pkg.sv
// Shared opcode encodings and FSM state type for the execution stage.
package exec_pkg;

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpAddu  = 4'b0011;
  localparam logic [3:0] OpSubu  = 4'b0100;
  localparam logic [3:0] OpSlt   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpPass  = 4'b0111;
  localparam logic [3:0] OpMult  = 4'b1000;
  localparam logic [3:0] OpMultu = 4'b1001;
  localparam logic [3:0] OpDiv   = 4'b1010;
  localparam logic [3:0] OpDivu  = 4'b1011;
  localparam logic [3:0] OpNor   = 4'b1100;
  localparam logic [3:0] OpMfhi  = 4'b1101;
  localparam logic [3:0] OpMflo  = 4'b1110;

  typedef enum logic [1:0] {StIdle, StBusy, StFix} state_e;

  // Opcodes 10xx run on the iterative multiply/divide engine.
  function automatic logic is_muldiv(logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Operation-in / result-out handshake bundle of the execution stage.
interface exec_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluctrl;
  logic [WIDTH-1:0] d1_in;
  logic [WIDTH-1:0] d2_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  in_valid, aluctrl, d1_in, d2_in, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, hi, lo
  );

  modport master (
    output in_valid, aluctrl, d1_in, d2_in, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction applied combinationally on the final registers.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q, acc_d, low_q, low_d, m_q, dividend_q;
  logic               div_q, neg_res_q, neg_rem_q, div0_q;
  logic               is_div, is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted;
  logic               fits;
  logic [2*WIDTH-1:0] prod;

  // Decode the starting op and take operand magnitudes for signed forms.
  always_comb begin
    is_div    = (op_i == OpDiv) || (op_i == OpDivu);
    is_signed = (op_i == OpMult) || (op_i == OpDiv);
    mag_a     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // One iteration: {acc,low} shifts right with add (mul) or left with trial subtract (div).
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, m_q};
    shifted = {acc_q, low_q[WIDTH-1]};
    fits    = shifted >= {1'b0, m_q};
    if (div_q) begin
      acc_d = fits ? WIDTH'(shifted - {1'b0, m_q}) : shifted[WIDTH-1:0];
      low_d = {low_q[WIDTH-2:0], fits};
    end else if (low_q[0]) begin
      {acc_d, low_d} = {sum, low_q[WIDTH-1:1]};
    end else begin
      {acc_d, low_d} = {1'b0, acc_q, low_q[WIDTH-1:1]};
    end
  end

  // Operand load on start, then one step per cycle until the counter empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      m_q        <= '0;
      dividend_q <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else if (start_i) begin
      cnt_q      <= CNT_W'(WIDTH);
      acc_q      <= '0;
      low_q      <= mag_a;
      m_q        <= mag_b;
      dividend_q <= a_i;
      div_q      <= is_div;
      neg_res_q  <= is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem_q  <= is_signed && a_i[WIDTH-1];
      div0_q     <= (b_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= acc_d;
      low_q <= low_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

  // Sign fix: product/quotient take sign(a)^sign(b), remainder takes sign(a).
  always_comb begin
    prod = {acc_q, low_q};
    if (neg_res_q) prod = -prod;
    if (div_q) begin
      if (div0_q) begin
        lo_o = '1;
        hi_o = dividend_q;
      end else begin
        lo_o = neg_res_q ? -low_q : low_q;
        hi_o = neg_rem_q ? -acc_q : acc_q;
      end
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Handshaked execution stage: single-cycle ALU, iterative mul/div, HI/LO and
// a registered result with zero/overflow/illegal flags.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  exec_unit_if.slave bus
);
  state_e           state_q;
  logic             out_valid_q, zero_q, ovf_q, illegal_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             accept, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] a, b, sum, diff, alu_res;
  logic             alu_ovf, alu_ill;

  assign a            = bus.d1_in;
  assign b            = bus.d2_in;
  assign bus.in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = illegal_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // Single-cycle ALU; mul/div opcodes produce nothing here.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.aluctrl)
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpNor:  alu_res = ~(a | b);
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpAddu: alu_res = sum;
      OpSub: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpSubu: alu_res = diff;
      OpPass: alu_res = b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpMfhi: alu_res = hi_q;
      OpMflo: alu_res = lo_q;
      OpMult, OpMultu, OpDiv, OpDivu: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && is_muldiv(bus.aluctrl)),
    .op_i    (bus.aluctrl),
    .a_i     (a),
    .b_i     (b),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  // Control FSM with registered result, flags and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_muldiv(bus.aluctrl)) begin
              state_q <= StBusy;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              ovf_q       <= alu_ovf;
              illegal_q   <= alu_ill;
              out_valid_q <= 1'b1;
            end
          end
        end
        StBusy: if (md_done) state_q <= StFix;
        StFix: begin
          hi_q        <= md_hi;
          lo_q        <= md_lo;
          result_q    <= md_lo;
          zero_q      <= (md_lo == '0);
          ovf_q       <= 1'b0;
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
